// File: rtl/buff_fifo.sv
// Parametrised first-word-fall-through valid/ready FIFO with fill level and watermarks.
// Define BUFF_FIFO_FLUSH_EN to enable the synchronous flush input; otherwise flush is ignored.
module buff_fifo #(
    parameter int unsigned DATA_WIDTH    = 8,
    parameter int unsigned DEPTH         = 16,
    parameter int unsigned AFULL_THRESH  = DEPTH - 2,
    parameter int unsigned AEMPTY_THRESH = 2,
    localparam int unsigned LVL_W        = $clog2(DEPTH) + 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] data_i,
    input  logic                  valid_in,
    output logic                  ready_in,
    output logic [DATA_WIDTH-1:0] data_o,
    output logic                  valid_out,
    input  logic                  ready_out,
    input  logic                  flush,
    output logic [LVL_W-1:0]      level,
    output logic                  almost_full,
    output logic                  almost_empty
);

    localparam int unsigned AW    = $clog2(DEPTH);
    localparam int unsigned PTR_W = AW + 1;

    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_depth_check
        $error("buff_fifo: DEPTH must be a power of two and at least 2");
    end

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0]      wr_ptr;
    logic [PTR_W-1:0]      rd_ptr;
    logic                  full;
    logic                  empty;
    logic                  wr_fire;
    logic                  rd_fire;
    logic                  do_flush;

`ifdef BUFF_FIFO_FLUSH_EN
    assign do_flush = flush;
`else
    logic unused_flush;
    assign unused_flush = flush;
    assign do_flush     = 1'b0;
`endif

    // Wrap bit distinguishes full from empty when the index bits match
    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

    assign ready_in  = !full;
    assign valid_out = !empty;
    assign wr_fire   = valid_in && ready_in;
    assign rd_fire   = valid_out && ready_out;

    assign data_o = mem[rd_ptr[AW-1:0]];

    assign level        = LVL_W'(wr_ptr - rd_ptr);
    assign almost_full  = (level >= LVL_W'(AFULL_THRESH));
    assign almost_empty = (level <= LVL_W'(AEMPTY_THRESH));

    // Storage is not reset; stale writes beyond a flush/reset are unreachable via the pointers
    always_ff @(posedge clk) begin
        if (wr_fire) begin
            mem[wr_ptr[AW-1:0]] <= data_i;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (do_flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (wr_fire) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (rd_fire) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_buff_fifo.sv
// Scoreboard bench for buff_fifo: directed stimulus pushes expected words, a monitor pops on each read.
module tb_buff_fifo;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] data_i;
    logic       valid_in;
    logic       ready_in;
    logic [7:0] data_o;
    logic       valid_out;
    logic       ready_out;
    logic       flush;
    logic [4:0] level;
    logic       almost_full;
    logic       almost_empty;

    int n_checks = 0;
    int n_fail   = 0;
    logic [7:0] sb [$];

    buff_fifo dut (
        .clk         (clk),
        .rst         (rst),
        .data_i      (data_i),
        .valid_in    (valid_in),
        .ready_in    (ready_in),
        .data_o      (data_o),
        .valid_out   (valid_out),
        .ready_out   (ready_out),
        .flush       (flush),
        .level       (level),
        .almost_full (almost_full),
        .almost_empty(almost_empty)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Queue a write that the bench expects the FIFO to accept, then advance one cycle
    task automatic push_write(input logic [7:0] d);
        valid_in = 1'b1;
        data_i   = d;
        sb.push_back(d);
        step();
        valid_in = 1'b0;
    endtask

    task automatic drain(input int n);
        ready_out = 1'b1;
        repeat (n) step();
        ready_out = 1'b0;
    endtask

    // Monitor: every read handshake must present the oldest expected word
    always @(negedge clk) begin
        if (!rst && valid_out && ready_out) begin
            if (sb.size() == 0) begin
                chk("sb_underflow", 1, 0);
            end else begin
                chk("data_o", int'(data_o), int'(sb.pop_front()));
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; valid_in = 1'b0; ready_out = 1'b0; flush = 1'b0; data_i = '0;
        step();
        step();
        rst = 1'b0;
        step();
        chk("rst_valid_out",    int'(valid_out),    0);
        chk("rst_ready_in",     int'(ready_in),     1);
        chk("rst_level",        int'(level),        0);
        chk("rst_almost_empty", int'(almost_empty), 1);
        chk("rst_almost_full",  int'(almost_full),  0);

        // Fill to full with the consumer stalled
        for (int i = 0; i < 16; i++) begin
            push_write(8'(i));
            chk("fill_level",    int'(level),       i + 1);
            chk("fill_afull",    int'(almost_full), (i + 1 >= 14) ? 1 : 0);
            chk("fill_ready_in", int'(ready_in),    (i + 1 < 16) ? 1 : 0);
            chk("fill_aempty",   int'(almost_empty), (i + 1 <= 2) ? 1 : 0);
        end
        chk("full_valid_out", int'(valid_out), 1);
        drain(16);
        chk("drained_valid_out", int'(valid_out), 0);
        chk("drained_level",     int'(level),     0);
        chk("drained_sb",        sb.size(),       0);

        // Alternating write/read across the pointer wrap
        for (int i = 0; i < 40; i++) begin
            push_write(8'(8'h80 + i));
            chk("wrap_level_w", int'(level), 1);
            drain(1);
            chk("wrap_level_r", int'(level), 0);
        end

        // Full with simultaneous valid_in and ready_out: read fires, write refused
        for (int i = 0; i < 16; i++) push_write(8'(8'h10 + i));
        chk("full2_level", int'(level), 16);
        valid_in = 1'b1; data_i = 8'hAA; ready_out = 1'b1;
        step();
        chk("full_rd_level", int'(level), 15);
        ready_out = 1'b0;
        push_write(8'hAA);
        chk("full_aa_level",    int'(level),    16);
        chk("full_aa_ready_in", int'(ready_in), 0);
        drain(16);
        chk("full_drain_level", int'(level), 0);
        chk("full_drain_sb",    sb.size(),   0);

        // Backpressure: head must hold while the consumer stalls
        push_write(8'h31);
        push_write(8'h32);
        push_write(8'h33);
        for (int i = 0; i < 5; i++) begin
            step();
            chk("bp_data_o",    int'(data_o),    8'h31);
            chk("bp_valid_out", int'(valid_out), 1);
        end
        drain(3);
        chk("bp_level", int'(level), 0);

        // Flush with a concurrent write
        for (int i = 0; i < 5; i++) push_write(8'(8'h50 + i));
        chk("pre_flush_level", int'(level), 5);
        valid_in = 1'b1; data_i = 8'h55; flush = 1'b1;
`ifdef BUFF_FIFO_FLUSH_EN
        sb.delete();
        step();
        flush = 1'b0; valid_in = 1'b0;
        chk("flush_level",     int'(level),     0);
        chk("flush_valid_out", int'(valid_out), 0);
        chk("flush_ready_in",  int'(ready_in),  1);
`else
        sb.push_back(8'h55);
        step();
        flush = 1'b0; valid_in = 1'b0;
        chk("noflush_level", int'(level), 6);
        drain(6);
        chk("noflush_drain_level", int'(level), 0);
`endif
        step();
        chk("final_sb_empty", sb.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
